int_req_ctrl: RTL

System-side interrupt request controller for the 6502C core: the source end of the CPU's `nmi`/`irq` interrupt interface. It aggregates peripheral and video interrupt sources into memory-mapped, maskable status registers. It drives the CPU's active-high `irq` level and `nmi` edge. It watches `cpu_sync` and the CPU address bus to complete the NMI handshake. It sits between the ANTIC/POKEY-style sources and the CPU core, in the same clock domain as the bus interface.

---
 rtl/int_req_ctrl_pkg.sv | 17 +
 rtl/int_req_ctrl_edge.sv | 17 +
 rtl/int_req_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/int_req_ctrl_pkg.sv
// int_req_ctrl_pkg: shared register offsets, NMI bit positions, NMI FSM encodings and NMI vector address
package int_req_ctrl_pkg;
    localparam logic [1:0] REG_IRQEN  = 2'd0;
    localparam logic [1:0] REG_IRQST  = 2'd0;
    localparam logic [1:0] REG_NMIEN  = 2'd1;
    localparam logic [1:0] REG_NMIST  = 2'd1;
    localparam logic [1:0] REG_NMIRES = 2'd2;
    localparam int NMI_DLI_BIT   = 7;
    localparam int NMI_VBI_BIT   = 6;
    localparam int NMI_RESET_BIT = 5;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } nmi_state_t;
    localparam logic [15:0] NMI_VECTOR = 16'hFFFA;
endpackage

// File: rtl/int_req_ctrl_edge.sv
// edge_rise_det: per-bit rising-edge detector against a registered previous level
//   clk, rst     clock and synchronous active-high reset
//   src  [W-1:0] level inputs
//   rise [W-1:0] high for each bit that is high now and was low on the previous cycle
module edge_rise_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] src,
    output logic [W-1:0] rise
);
    logic [W-1:0] prev;
    // prev tracks the live level even in reset, so sources already high at reset are not events
    always_ff @(posedge clk) prev <= src;
    assign rise = rst ? '0 : src & ~prev;
endmodule

// File: rtl/int_req_ctrl.sv
// int_req_ctrl: maskable IRQ/NMI status registers driving the 6502C irq level and nmi edge
//   clk, rst                  clock and synchronous active-high reset
//   irq_src[7:0]              peripheral IRQ sources (rising edge = event)
//   nmi_src[2:0]              {DLI, VBI, RESET key} (rising edge = event)
//   cs, we, addr[1:0], wdata  register write/read port; rdata is registered
//   cpu_sync, cpu_addr, cpu_rw  CPU bus, watched for the NMI vector fetch handshake
//   irq, nmi                  interrupt outputs to the CPU
//   INT_VECTOR_ACK_EN         when defined, nmi is held until vector fetch or cpu_sync timeout;
//                             otherwise nmi is a fixed NMI_PULSE-cycle pulse
module int_req_ctrl
    import int_req_ctrl_pkg::*;
#(
    parameter int NMI_PULSE   = 2,
    parameter int NMI_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq_src,
    input  logic [2:0]  nmi_src,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        cpu_sync,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    output logic        irq,
    output logic        nmi
);
    logic [7:0] irq_rise, irqen, irqen_n, irq_pend, irq_pend_n, nmist, rdata_n;
    logic [2:0] nmi_rise, nmi_pend, nmi_pend_n, nmi_en;
    logic [1:0] nmien;
    logic wr_irqen, wr_nmien, wr_nmires, rd, nmi_req, nmi_req_n, take, done;
    nmi_state_t state, state_n;

    edge_rise_det #(.W(8)) u_irq_det (.clk(clk), .rst(rst), .src(irq_src), .rise(irq_rise));
    edge_rise_det #(.W(3)) u_nmi_det (.clk(clk), .rst(rst), .src(nmi_src), .rise(nmi_rise));

    assign wr_irqen  = cs & we & (addr == REG_IRQEN);
    assign wr_nmien  = cs & we & (addr == REG_NMIEN);
    assign wr_nmires = cs & we & (addr == REG_NMIRES);
    assign rd        = cs & ~we;
    assign nmi_en    = {nmien, 1'b1};

    // Sets are ORed in after clears so a same-cycle set wins; the new mask gates the set
    always_comb begin
        irqen_n    = wr_irqen ? wdata : irqen;
        irq_pend_n = (irq_pend & (wr_irqen ? wdata : 8'hFF)) | (irq_rise & irqen_n);
        nmi_pend_n = (wr_nmires ? 3'b000 : nmi_pend) | nmi_rise;
        nmist                = 8'hFF;
        nmist[NMI_DLI_BIT]   = nmi_pend[2];
        nmist[NMI_VBI_BIT]   = nmi_pend[1];
        nmist[NMI_RESET_BIT] = nmi_pend[0];
        rdata_n = addr == REG_IRQST ? ~irq_pend : addr == REG_NMIST ? nmist : 8'hFF;
    end

    // A request waiting at the end of GAP goes straight back to ASSERT, giving one low cycle
    always_comb begin
        take      = nmi_req & (state != ST_ASSERT);
        state_n   = take ? ST_ASSERT : state == ST_ASSERT ? (done ? ST_GAP : ST_ASSERT) : ST_IDLE;
        nmi_req_n = (|(nmi_rise & nmi_en)) | (nmi_req & ~take);
    end

    always_ff @(posedge clk) state <= rst ? ST_IDLE : state_n;

`ifdef INT_VECTOR_ACK_EN
    localparam int CW = $clog2(NMI_TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic sync_q, sync_rise;
    assign sync_rise = cpu_sync & ~sync_q;
    assign done = (cpu_rw && cpu_addr == NMI_VECTOR) || (sync_rise && cnt == CW'(NMI_TIMEOUT - 1));
    always_ff @(posedge clk) begin
        sync_q <= cpu_sync;
        cnt    <= (rst || state != ST_ASSERT) ? '0 : cnt + CW'(sync_rise);
    end
`else
    localparam int CW = $clog2(NMI_PULSE + 1);
    logic [CW-1:0] cnt;
    logic unused_cpu_bus;
    assign unused_cpu_bus = ^{cpu_sync, cpu_addr, cpu_rw};
    assign done = cnt == CW'(NMI_PULSE - 1);
    always_ff @(posedge clk) cnt <= (rst || state != ST_ASSERT) ? '0 : cnt + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            irqen    <= '0;
            irq_pend <= '0;
            nmien    <= '0;
            nmi_pend <= '0;
            nmi_req  <= 1'b0;
            irq      <= 1'b0;
            nmi      <= 1'b0;
            rdata    <= 8'hFF;
        end else begin
            irqen    <= irqen_n;
            irq_pend <= irq_pend_n;
            nmien    <= wr_nmien ? {wdata[NMI_DLI_BIT], wdata[NMI_VBI_BIT]} : nmien;
            nmi_pend <= nmi_pend_n;
            nmi_req  <= nmi_req_n;
            irq      <= |(irq_pend & irqen);
            nmi      <= state_n == ST_ASSERT;
            rdata    <= rd ? rdata_n : rdata;
        end
    end
endmodule
